instr_fetch: RTL
================

Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Holds the PC and issues word requests to instruction memory over a req/ack handshake. Latches each returned word into an instruction register. Presents the word to decode with a valid/ready handshake, with the opcode field broken out to feed the immediate-select decoder. Accepts branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word address of request (byte address, bits [1:0]=00)
imem_ack  input  1  imem_rdata valid this cycle; only meaningful while imem_req=1
imem_rdata  input  32  instruction word from memory
instr_valid  output  1  instr/instr_pc/pc_plus4/op valid for decode
instr_ready  input  1  decode accepts current instruction
instr  output  32  instruction register
op  output  7  instr[6:0], opcode to decoder
instr_pc  output  32  PC of instr
pc_plus4  output  32  instr_pc + 4
redirect  input  1  branch/jump taken; discard in-flight and held instruction
redirect_pc  input  32  new fetch target
fetch_fault  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on port `reset`.
- States: IDLE, REQ, HOLD, FLUSH (plus FAULT with the optional feature).
- Reset values: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, imem_req=0, fetch_fault=0.
- imem_req=1 exactly in REQ and FLUSH; imem_addr=pc. imem_addr is stable while imem_req=1 and no ack has been received.
- IDLE: go to REQ next cycle unconditionally. ack and redirect are ignored except that a redirect loads pc.
- REQ, ack=1, redirect=0: instr<=imem_rdata, instr_pc<=pc, go to HOLD. instr_valid=1 in the following cycle. A zero-wait ack in the same cycle as the first req is legal.
- REQ, ack=0, redirect=1: save target in pend_pc, go to FLUSH. The address must not change while the request is outstanding.
- REQ, ack=1, redirect=1: discard rdata, pc<=redirect_pc, stay in REQ.
- HOLD: instr_valid=1 and all outputs stable.
  - instr_ready=1 and redirect=0: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), go to REQ.
  - redirect=1 (takes priority over instr_ready): pc<=redirect_pc, instr_valid<=0, go to REQ. The held instruction is not consumed.
- FLUSH: keep requesting the old address. A redirect in FLUSH overwrites pend_pc. On ack: discard data, pc<=pend_pc (or redirect_pc if redirect is asserted the same cycle), go to REQ.
- instr_valid is never 1 in REQ, FLUSH or IDLE.
- Throughput: one instruction per 2 cycles at zero memory wait.
- Reset mid-transaction: return to IDLE and drop any outstanding request. Instruction memory shares the same reset, so no stale ack is produced.
- op and pc_plus4 are combinational from instr and instr_pc.

Optional Feature:
Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Any accepted redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky) and enters FAULT.
  - FAULT: imem_req=0, instr_valid=0, all inputs ignored until reset.
  - An outstanding request is abandoned.
- Undefined: redirect_pc[1:0] is forced to 00 on load, fetch_fault is tied 0, and no FAULT state exists.

Test Plan:
- Reset release, ack one cycle after each req, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_valid pulses with instr_pc matching; op equals rdata[6:0] (e.g. 0x00500093 -> op=7'h13).
- instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, instr_valid held 1; release -> next addr = instr_pc+4.
- redirect to 0x100 while REQ at 0x8 with ack delayed 3 cycles -> imem_addr stays 0x8 until ack, data discarded, next req at 0x100, no instr_valid for 0x8.
- redirect to 0x200 in HOLD with instr_ready=1 same cycle -> held instruction dropped, next req at 0x200.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_fault=1, imem_req=0 until reset; without the macro -> fetch at 0x100.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ack, instruction register, decode handshake.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_FLUSH, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FLUSH} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic tgt_bad;
    assign tgt     = redirect_pc;
    assign tgt_bad = |redirect_pc[1:0];
`else
    logic unused_rpc_lsb;
    assign tgt            = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc[1:0];
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = tgt;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack && redirect) begin
                    pc_d = tgt;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end else if (redirect) begin
                    // address must stay put until the outstanding word returns
                    pend_pc_d = tgt;
                    state_d   = S_FLUSH;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_FLUSH: begin
                if (imem_ack) begin
                    pc_d    = redirect ? tgt : pend_pc_q;
                    state_d = S_REQ;
                end else if (redirect) begin
                    pend_pc_d = tgt;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_FAULT: ;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
        // a misaligned target overrides every other transition, abandoning any request
        if (state_q != S_FAULT && redirect && tgt_bad) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            instr_q    <= 32'h0000_0013;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req    = (state_q == S_REQ) || (state_q == S_FLUSH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;

endmodule
